// File: rtl/cory_merge2_rr_pkg.sv
// Shared definitions for the cory arbiters: grant FSM encodings and a
// constant-foldable ceil(log2) used to size beat counters.
package cory_merge2_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cory_merge2_rr_fifo2.sv
// Two-entry valid/ready FIFO. The head entry drives the outputs directly
// from flops; a second skid entry absorbs one beat while the sink stalls.
module cory_merge2_rr_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_v,
  input  logic [W-1:0] i_d,
  output logic         o_r,
  output logic         o_v,
  output logic [W-1:0] o_d,
  input  logic         i_r
);

  logic [1:0]   cnt;
  logic [W-1:0] head;
  logic [W-1:0] skid;
  logic         push;
  logic         pop;

  assign o_r  = (cnt != 2'd2);
  assign o_v  = (cnt != 2'd0);
  assign o_d  = head;
  assign push = i_v & o_r;
  assign pop  = o_v & i_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= 2'd0;
      head <= '0;
    end else begin
      if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) head <= i_d;
      else if (pop && cnt == 2'd2)                       head <= skid;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Skid only fills when a push lands behind an occupied, non-draining head.
  always_ff @(posedge clk) begin
    if (push && cnt == 2'd1 && !pop) skid <= i_d;
  end

endmodule

// File: rtl/cory_merge2_rr.sv
// Two-input round-robin merge with burst lock of up to B beats per grant;
// each beat is tagged with its source and leaves through a 2-entry buffer.
module cory_merge2_rr
  import cory_merge2_rr_pkg::*;
#(
  parameter int N = 8,
  parameter int B = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_a0_v,
  input  logic [N-1:0] i_a0_d,
  output logic         o_a0_r,
  input  logic         i_a1_v,
  input  logic [N-1:0] i_a1_d,
  output logic         o_a1_r,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic         o_z_id,
  input  logic         i_z_r,
  output logic         o_busy
);

  localparam int BW = clog2(B) + 1;

  arb_state_t    state;
  logic          ptr;
  logic [BW-1:0] beats;
  logic          buf_in_r;
  logic          buf_push;
  logic [N:0]    buf_in_d;
  logic [N:0]    buf_out_d;
  logic          gnt_id;
  logic          gnt_v;
  logic          gnt_r;
  logic          oth_v;
  logic [N-1:0]  gnt_d;

  // Readies come only from registered state, never from the source valids.
  assign o_a0_r   = (state == ST_G0) & buf_in_r;
  assign o_a1_r   = (state == ST_G1) & buf_in_r;
  assign gnt_id   = (state == ST_G1);
  assign gnt_v    = gnt_id ? i_a1_v : i_a0_v;
  assign gnt_d    = gnt_id ? i_a1_d : i_a0_d;
  assign oth_v    = gnt_id ? i_a0_v : i_a1_v;
  assign gnt_r    = o_a0_r | o_a1_r;
  assign buf_push = gnt_r & gnt_v;
  assign buf_in_d = {gnt_id, gnt_d};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      ptr   <= 1'b0;
      beats <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_a0_v && i_a1_v) state <= ptr ? ST_G1 : ST_G0;
          else if (i_a0_v)      state <= ST_G0;
          else if (i_a1_v)      state <= ST_G1;
        end
        ST_G0, ST_G1: begin
          // A buffer stall leaves gnt_r low, so it neither counts nor releases.
          if ((buf_push && beats == BW'(B - 1)) || (gnt_r && !gnt_v)) begin
            ptr   <= ~gnt_id;
            beats <= '0;
            state <= oth_v ? (gnt_id ? ST_G0 : ST_G1) : ST_IDLE;
          end else if (buf_push) begin
            beats <= beats + BW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- output buffer stage ----
  cory_merge2_rr_fifo2 #(.W(N + 1)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .i_v     (buf_push),
    .i_d     (buf_in_d),
    .o_r     (buf_in_r),
    .o_v     (o_z_v),
    .o_d     (buf_out_d),
    .i_r     (i_z_r)
  );

  assign o_z_id = buf_out_d[N];
  assign o_z_d  = buf_out_d[N-1:0];
  assign o_busy = (state != ST_IDLE) | o_z_v;

`ifndef SYNTHESIS
  logic         chk_pend;
  logic [N-1:0] chk_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chk_pend <= 1'b0;
    else          chk_pend <= (state != ST_IDLE) & gnt_v & ~gnt_r;
  end

  always_ff @(posedge clk) begin
    chk_d <= gnt_d;
  end

  // A stalled grant keeps its state, so gnt_* still refers to the same source.
  always @(posedge clk) begin
    if (B < 1 || B > 256) begin
      $error("ERROR: B=%0d outside 1..256", B);
      $finish;
    end
    if (reset_n && chk_pend && (!gnt_v || gnt_d != chk_d)) begin
      $error("ERROR: source %0d dropped valid or changed data before acceptance", gnt_id);
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_cory_merge2_rr.sv
// Directed bench for cory_merge2_rr: a queue scoreboard checks every cycle,
// and hand-computed beat orders and latencies pin each scenario.
module tb_cory_merge2_rr;
  localparam int N = 8;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_a0_v = 1'b0;
  logic [N-1:0] i_a0_d = '0;
  logic         o_a0_r;
  logic         i_a1_v = 1'b0;
  logic [N-1:0] i_a1_d = '0;
  logic         o_a1_r;
  logic         o_z_v;
  logic [N-1:0] o_z_d;
  logic         o_z_id;
  logic         i_z_r = 1'b1;
  logic         o_busy;

  always #5 clk = ~clk;

  cory_merge2_rr #(.N(N), .B(B)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_a0_v(i_a0_v), .i_a0_d(i_a0_d), .o_a0_r(o_a0_r),
    .i_a1_v(i_a1_v), .i_a1_d(i_a1_d), .o_a1_r(o_a1_r),
    .o_z_v(o_z_v), .o_z_d(o_z_d), .o_z_id(o_z_id), .i_z_r(i_z_r),
    .o_busy(o_busy)
  );

  logic [N:0]   mq[$];
  logic [N-1:0] q0[$];
  logic [N-1:0] q1[$];
  int lg_id[$];
  int lg_d[$];
  int lg_c[$];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc0 = 0;
  int n_acc1 = 0;
  int tstart = 0;
  bit acc0 = 0;
  bit acc1 = 0;
  bit a1r_seen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard step at the falling edge: outputs against the model, then
  // record which handshakes the coming rising edge will complete.
  task automatic model_step();
    if (!reset_n) begin
      chk("rst_z_v", int'(o_z_v), 0);
      chk("rst_a0_r", int'(o_a0_r), 0);
      chk("rst_a1_r", int'(o_a1_r), 0);
      chk("rst_busy", int'(o_busy), 0);
      mq.delete();
      acc0 = 0;
      acc1 = 0;
    end else begin
      chk("z_v_model", int'(o_z_v), int'(mq.size() != 0));
      if (mq.size() != 0) chk("z_beat_model", int'({o_z_id, o_z_d}), int'(mq[0]));
      chk("one_grant", int'(o_a0_r & o_a1_r), 0);
      if (mq.size() == 2) chk("full_no_ready", int'(o_a0_r | o_a1_r), 0);
      if (mq.size() != 0 || o_a0_r || o_a1_r) chk("busy", int'(o_busy), 1);
      if (o_a1_r) a1r_seen = 1;
      acc0 = i_a0_v & o_a0_r;
      acc1 = i_a1_v & o_a1_r;
      if (o_z_v && i_z_r) begin
        lg_id.push_back(int'(o_z_id));
        lg_d.push_back(int'(o_z_d));
        lg_c.push_back(cyc);
        if (mq.size() != 0) void'(mq.pop_front());
      end
      if (acc0) begin mq.push_back({1'b0, i_a0_d}); n_acc0++; end
      if (acc1) begin mq.push_back({1'b1, i_a1_d}); n_acc1++; end
    end
  endtask

  // Sources present the head of their queue and hold it until accepted.
  task automatic drive();
    if (reset_n && acc0 && q0.size() != 0) void'(q0.pop_front());
    if (reset_n && acc1 && q1.size() != 0) void'(q1.pop_front());
    acc0 = 0;
    acc1 = 0;
    i_a0_v = (q0.size() != 0);
    i_a0_d = (q0.size() != 0) ? q0[0] : '0;
    i_a1_v = (q1.size() != 0);
    i_a1_d = (q1.size() != 0) ? q1[0] : '0;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    cyc++;
    #1;
    drive();
    #1;
  endtask

  task automatic clear_log();
    lg_id.delete();
    lg_d.delete();
    lg_c.delete();
    n_acc0 = 0;
    n_acc1 = 0;
    a1r_seen = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    tick();
    tick();
    reset_n = 1'b1;
    clear_log();
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((q0.size() != 0 || q1.size() != 0 || o_busy) && n < 200);
    chk({nm, "_drain"}, int'(n < 200), 1);
  endtask

  task automatic check_log(input string nm, input int ei[$], input int ed[$]);
    chk({nm, "_count"}, lg_d.size(), ed.size());
    for (int i = 0; i < ed.size(); i++) begin
      if (i < lg_d.size()) begin
        chk($sformatf("%s_id%0d", nm, i), lg_id[i], ei[i]);
        chk($sformatf("%s_d%0d", nm, i), lg_d[i], ed[i]);
      end
    end
  endtask

  initial begin
    int ei[$];
    int ed[$];
    int n;

    #1;
    chk("reset_z_v", int'(o_z_v), 0);
    chk("reset_z_d", int'(o_z_d), 0);
    chk("reset_z_id", int'(o_z_id), 0);
    chk("reset_a0_r", int'(o_a0_r), 0);
    chk("reset_a1_r", int'(o_a1_r), 0);
    chk("reset_busy", int'(o_busy), 0);
    tick();
    tick();
    reset_n = 1'b1;
    clear_log();

    // Single source, back-to-back beats
    q0 = '{8'h11, 8'h22, 8'h33};
    tstart = cyc + 1;
    wait_idle("t1");
    check_log("t1", '{0, 0, 0}, '{32'h11, 32'h22, 32'h33});
    if (lg_c.size() == 3) begin
      chk("t1_latency", lg_c[0], tstart + 2);
      chk("t1_back2back", lg_c[2] - lg_c[0], 2);
    end
    chk("t1_a1_ready", int'(a1r_seen), 0);

    // Both sources continuously valid: groups of B, alternating, no gaps
    do_reset();
    ei.delete();
    ed.delete();
    for (int i = 0; i < 12; i++) begin
      q0.push_back(8'(i));
      q1.push_back(8'(8'h80 + i));
    end
    for (int i = 0; i < 24; i++) begin
      ei.push_back((i / B) % 2);
      ed.push_back(((i / B) % 2) * 32'h80 + (i / (2 * B)) * B + (i % B));
    end
    tstart = cyc + 1;
    wait_idle("t2");
    check_log("t2", ei, ed);
    if (lg_c.size() == 24) begin
      chk("t2_latency", lg_c[0], tstart + 2);
      chk("t2_no_gap", lg_c[23] - lg_c[0], 23);
      chk("t2_pin_d4", lg_d[4], 32'h80);
      chk("t2_pin_d8", lg_d[8], 32'h04);
      chk("t2_pin_id12", lg_id[12], 1);
    end

    // Early release: a0 goes idle after 2 beats, a1 takes over
    do_reset();
    q0 = '{8'h31, 8'h32};
    q1 = '{8'hB1, 8'hB2, 8'hB3};
    wait_idle("t3a");
    q0 = '{8'h41};
    q1 = '{8'hC1};
    wait_idle("t3b");
    check_log("t3", '{0, 0, 1, 1, 1, 0, 1},
              '{32'h31, 32'h32, 32'hB1, 32'hB2, 32'hB3, 32'h41, 32'hC1});
    if (lg_c.size() == 7) chk("t3_switch_gap", lg_c[2] - lg_c[1], 2);

    // Backpressure: sink stalls, buffer fills after 2 beats, grant held
    do_reset();
    i_z_r = 1'b0;
    q0 = '{8'h51, 8'h52, 8'h53, 8'h54};
    repeat (6) tick();
    chk("t4_a0_r_stalled", int'(o_a0_r), 0);
    chk("t4_accepted", n_acc0, 2);
    chk("t4_hold_v", int'(o_z_v), 1);
    chk("t4_hold_d", int'(o_z_d), 32'h51);
    chk("t4_hold_id", int'(o_z_id), 0);
    i_z_r = 1'b1;
    wait_idle("t4");
    check_log("t4", '{0, 0, 0, 0}, '{32'h51, 32'h52, 32'h53, 32'h54});

    // Asynchronous reset in the middle of an a0 burst
    do_reset();
    q0 = '{8'h61, 8'h62, 8'h63, 8'h64};
    n = 0;
    while (n_acc0 < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("t5_two_beats", int'(n < 50), 1);
    chk("t5_busy_before", int'(o_busy), 1);
    chk("t5_z_v_before", int'(o_z_v), 1);
    #1;
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("t5_async_z_v", int'(o_z_v), 0);
    chk("t5_async_z_d", int'(o_z_d), 0);
    chk("t5_async_a0_r", int'(o_a0_r), 0);
    chk("t5_async_busy", int'(o_busy), 0);
    tick();
    tick();
    reset_n = 1'b1;
    clear_log();
    q1 = '{8'h71, 8'h72};
    tstart = cyc + 1;
    wait_idle("t5");
    check_log("t5", '{1, 1}, '{32'h71, 32'h72});
    if (lg_c.size() == 2) chk("t5_latency", lg_c[0], tstart + 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
